// File: rtl/video_pattern_gen_if.sv
// Parallel video bus between the pattern source and the TMDS encoders.
// Sync, data enable, frame/line markers, coordinates and RGB travel together.
interface video_pattern_gen_if #(
  parameter int COLOR_WIDTH = 8,
  parameter int COORD_WIDTH = 16
);
  logic                   hsync_o;
  logic                   vsync_o;
  logic                   de_o;
  logic                   frame_o;
  logic                   line_o;
  logic [COORD_WIDTH-1:0] x_o;
  logic [COORD_WIDTH-1:0] y_o;
  logic [COLOR_WIDTH-1:0] red_o;
  logic [COLOR_WIDTH-1:0] green_o;
  logic [COLOR_WIDTH-1:0] blue_o;

  modport master (
    output hsync_o, vsync_o, de_o, frame_o, line_o,
    output x_o, y_o, red_o, green_o, blue_o
  );

  modport slave (
    input hsync_o, vsync_o, de_o, frame_o, line_o,
    input x_o, y_o, red_o, green_o, blue_o
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing generator and test-pattern source in the pixel clock domain.
// Counter state (h,v) feeds a two-register pipeline; every output on the bus
// reflects the counter state of two cycles earlier.
module video_pattern_gen #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          H_FP         = 110,
  parameter int          H_SYNC       = 40,
  parameter int          H_BP         = 220,
  parameter int          V_ACTIVE     = 720,
  parameter int          V_FP         = 5,
  parameter int          V_SYNC       = 5,
  parameter int          V_BP         = 20,
  parameter bit          HSYNC_POL    = 1'b1,
  parameter bit          VSYNC_POL    = 1'b1,
  parameter int          COLOR_WIDTH  = 8,
  parameter int          COORD_WIDTH  = 16,
  parameter int          CHECKER_LOG2 = 5,
  parameter int          GRAD_SHIFT   = 2,
  parameter logic [15:0] SEED_R       = 16'hACE1,
  parameter logic [15:0] SEED_G       = 16'h1234,
  parameter logic [15:0] SEED_B       = 16'hBEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2:0]               mode_i,
  input  logic [3*COLOR_WIDTH-1:0] solid_rgb_i,
  video_pattern_gen_if.master      vid
);

  typedef logic [COORD_WIDTH-1:0] coord_t;
  typedef logic [COLOR_WIDTH-1:0] chan_t;

  localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int     BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t BAR_LAST = coord_t'(BAR_W - 1);
  localparam chan_t  FULL     = '1;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Bar index to {R,G,B} on/off: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Top COLOR_WIDTH bits of an LFSR state form one noise channel.
  function automatic chan_t noise_chan(input logic [15:0] s);
    return s[15 -: COLOR_WIDTH];
  endfunction

  coord_t                   h_p0, v_p0, bar_px_p0;
  logic [2:0]               bar_idx_p0, mode_q, mode_sel;
  logic [3*COLOR_WIDTH-1:0] solid_q, solid_sel;
  logic [15:0]              lfsr_r, lfsr_g, lfsr_b;
  logic [15:0]              lfsr_r_nxt, lfsr_g_nxt, lfsr_b_nxt;
  logic                     at_origin;

  assign at_origin  = (h_p0 == '0) && (v_p0 == '0);
  // Mode and solid colour only change at the top-left pixel so a frame never tears.
  assign mode_sel   = at_origin ? mode_i : mode_q;
  assign solid_sel  = at_origin ? solid_rgb_i : solid_q;
  assign lfsr_r_nxt = lfsr_step(lfsr_r);
  assign lfsr_g_nxt = lfsr_step(lfsr_g);
  assign lfsr_b_nxt = lfsr_step(lfsr_b);

  // ---- stage p0: raster counters, bar counter, latched mode ----
  // Raster position plus a divider-free bar counter that tracks h.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_p0       <= '0;
      v_p0       <= '0;
      bar_px_p0  <= '0;
      bar_idx_p0 <= '0;
      mode_q     <= 3'd5;
      solid_q    <= '0;
    end else begin
      mode_q  <= mode_sel;
      solid_q <= solid_sel;
      if (h_p0 == H_LAST) begin
        h_p0       <= '0;
        bar_px_p0  <= '0;
        bar_idx_p0 <= '0;
        v_p0       <= (v_p0 == V_LAST) ? '0 : v_p0 + coord_t'(1);
      end else begin
        h_p0 <= h_p0 + coord_t'(1);
        if (bar_px_p0 == BAR_LAST) begin
          bar_px_p0 <= '0;
          if (bar_idx_p0 != 3'd7) bar_idx_p0 <= bar_idx_p0 + 3'd1;
        end else begin
          bar_px_p0 <= bar_px_p0 + coord_t'(1);
        end
      end
    end
  end

  // Noise generators run every cycle, blanking included, and restart on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_r <= SEED_R;
      lfsr_g <= SEED_G;
      lfsr_b <= SEED_B;
    end else begin
      lfsr_r <= lfsr_r_nxt;
      lfsr_g <= lfsr_g_nxt;
      lfsr_b <= lfsr_b_nxt;
    end
  end

  logic  de_c, hs_c, vs_c, noise_c, chk_c;
  logic [2:0] bars_c;
  chan_t r_c, g_c, b_c, grad_c;

  // Timing flags and non-noise pixel colour for the current counter position.
  always_comb begin
    de_c    = (h_p0 < H_ACT) && (v_p0 < V_ACT);
    hs_c    = (h_p0 >= HS_BEG) && (h_p0 < HS_END);
    vs_c    = (v_p0 >= VS_BEG) && (v_p0 < VS_END);
    bars_c  = bar_rgb(bar_idx_p0);
    grad_c  = chan_t'(h_p0 >> GRAD_SHIFT);
    chk_c   = h_p0[CHECKER_LOG2] ^ v_p0[CHECKER_LOG2];
    noise_c = 1'b0;
    r_c     = '0;
    g_c     = '0;
    b_c     = '0;
    if (de_c) begin
      case (mode_sel)
        3'd0: noise_c = 1'b1;
        3'd1: begin
          r_c = bars_c[2] ? FULL : '0;
          g_c = bars_c[1] ? FULL : '0;
          b_c = bars_c[0] ? FULL : '0;
        end
        3'd2: begin
          r_c = chk_c ? FULL : '0;
          g_c = chk_c ? FULL : '0;
          b_c = chk_c ? FULL : '0;
        end
        3'd3: begin
          r_c = grad_c;
          g_c = grad_c;
          b_c = grad_c;
        end
        3'd4: begin
          r_c = solid_sel[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
          g_c = solid_sel[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
          b_c = solid_sel[COLOR_WIDTH-1 -: COLOR_WIDTH];
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered timing flags and colour ----
  logic   hs_p1, vs_p1, de_p1, frame_p1, line_p1, noise_p1;
  coord_t x_p1, y_p1;
  chan_t  r_p1, g_p1, b_p1;

  // Capture the pixel description; reset forces the blank/inactive state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      de_p1    <= 1'b0;
      frame_p1 <= 1'b0;
      line_p1  <= 1'b0;
      noise_p1 <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      r_p1     <= '0;
      g_p1     <= '0;
      b_p1     <= '0;
    end else begin
      hs_p1    <= hs_c;
      vs_p1    <= vs_c;
      de_p1    <= de_c;
      frame_p1 <= at_origin;
      line_p1  <= (h_p0 == '0) && (v_p0 < V_ACT);
      noise_p1 <= noise_c;
      x_p1     <= h_p0;
      y_p1     <= v_p0;
      r_p1     <= r_c;
      g_p1     <= g_c;
      b_p1     <= b_c;
    end
  end

  // ---- stage p2: output registers ----
  // Apply sync polarity and substitute noise, which is taken from the LFSR
  // state loaded on this same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vid.hsync_o <= ~HSYNC_POL;
      vid.vsync_o <= ~VSYNC_POL;
      vid.de_o    <= 1'b0;
      vid.frame_o <= 1'b0;
      vid.line_o  <= 1'b0;
      vid.x_o     <= '0;
      vid.y_o     <= '0;
      vid.red_o   <= '0;
      vid.green_o <= '0;
      vid.blue_o  <= '0;
    end else begin
      vid.hsync_o <= hs_p1 ? HSYNC_POL : ~HSYNC_POL;
      vid.vsync_o <= vs_p1 ? VSYNC_POL : ~VSYNC_POL;
      vid.de_o    <= de_p1;
      vid.frame_o <= frame_p1;
      vid.line_o  <= line_p1;
      vid.x_o     <= x_p1;
      vid.y_o     <= y_p1;
      vid.red_o   <= noise_p1 ? noise_chan(lfsr_r_nxt) : r_p1;
      vid.green_o <= noise_p1 ? noise_chan(lfsr_g_nxt) : g_p1;
      vid.blue_o  <= noise_p1 ? noise_chan(lfsr_b_nxt) : b_p1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen with a small 25x12 raster: a reference model
// queues the expected bus word per clock and a monitor compares on negedge.
module tb_video_pattern_gen;
  localparam int CW = 8;
  localparam int XW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [2:0]    mode_i = 3'd0;
  logic [3*CW-1:0] solid_rgb_i = '0;

  always #5 clk = ~clk;

  video_pattern_gen_if #(.COLOR_WIDTH(CW), .COORD_WIDTH(XW)) vif ();
  video_pattern_gen_if #(.COLOR_WIDTH(CW), .COORD_WIDTH(XW)) vif_n ();

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_WIDTH(CW), .COORD_WIDTH(XW),
    .CHECKER_LOG2(2), .GRAD_SHIFT(1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .solid_rgb_i(solid_rgb_i), .vid(vif)
  );

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_WIDTH(CW), .COORD_WIDTH(XW),
    .CHECKER_LOG2(2), .GRAD_SHIFT(1)
  ) u_dut_n (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .solid_rgb_i(solid_rgb_i), .vid(vif_n)
  );

  typedef struct packed {
    logic        hs, vs, de, frame, line;
    logic [15:0] x, y;
    logic [7:0]  r, g, b;
  } vid_t;

  vid_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic expect_seed = 1'b1;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  // Expected bus word for raster position (h,v) in mode m.
  function automatic vid_t pixel(input int h, input int v, input logic [2:0] m,
                                 input logic [23:0] s);
    vid_t p;
    int   bi;
    logic [7:0] c;
    p       = '0;
    p.de    = (h < 16) && (v < 8);
    p.hs    = (h >= 18) && (h < 21);
    p.vs    = (v >= 9) && (v < 11);
    p.frame = (h == 0) && (v == 0);
    p.line  = (h == 0) && (v < 8);
    p.x     = 16'(h);
    p.y     = 16'(v);
    if (p.de) begin
      case (m)
        3'd1: begin
          bi = h / 2;
          if (bi > 7) bi = 7;
          {p.r, p.g, p.b} = bar_tab[bi];
        end
        3'd2: {p.r, p.g, p.b} = (((h >> 2) ^ (v >> 2)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
        3'd3: begin
          c = 8'(h >> 1);
          {p.r, p.g, p.b} = {c, c, c};
        end
        3'd4: {p.r, p.g, p.b} = s;
        default: {p.r, p.g, p.b} = 24'h0;
      endcase
    end
    return p;
  endfunction

  int          mh = 0, mv = 0;
  logic [15:0] lr, lg, lb;
  logic [2:0]  mmode;
  logic [23:0] msolid;
  vid_t        m_p1, m_out;
  logic        m_p1_noise;

  // Reference model: one step per rising edge, result pushed to the scoreboard.
  task automatic model_step();
    if (rst_i) begin
      mh = 0; mv = 0;
      lr = 16'hACE1; lg = 16'h1234; lb = 16'hBEEF;
      mmode = 3'd5; msolid = '0;
      m_p1 = '0; m_p1_noise = 1'b0; m_out = '0;
    end else begin
      if (mh == 0 && mv == 0) begin
        mmode = mode_i;
        msolid = solid_rgb_i;
      end
      m_out = m_p1;
      lr = ref_lfsr(lr); lg = ref_lfsr(lg); lb = ref_lfsr(lb);
      if (m_p1_noise) {m_out.r, m_out.g, m_out.b} = {lr[15:8], lg[15:8], lb[15:8]};
      m_p1 = pixel(mh, mv, mmode, msolid);
      m_p1_noise = (mmode == 3'd0) && m_p1.de;
      mh++;
      if (mh == 25) begin
        mh = 0;
        mv++;
        if (mv == 12) mv = 0;
      end
    end
    sb_q.push_back(m_out);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pop and compare each cycle, plus frame timing and seed checks.
  int   cyc = 0, rel_cyc = 0, last_frame = 0;
  logic prev_rst = 1'b1, wait_first = 1'b0, have_frame = 1'b0;

  initial forever begin
    vid_t e, a;
    @(negedge clk);
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      a.hs = vif.hsync_o; a.vs = vif.vsync_o; a.de = vif.de_o;
      a.frame = vif.frame_o; a.line = vif.line_o;
      a.x = vif.x_o; a.y = vif.y_o;
      a.r = vif.red_o; a.g = vif.green_o; a.b = vif.blue_o;
      check("bus", a, e);
      check("bus_inv_pol", {vif_n.hsync_o, vif_n.vsync_o, vif_n.de_o}, {~e.hs, ~e.vs, e.de});
    end
    if (rst_i) begin
      have_frame = 1'b0;
      prev_rst = 1'b1;
    end else if (prev_rst) begin
      rel_cyc = cyc;
      wait_first = 1'b1;
      prev_rst = 1'b0;
    end
    if (vif.frame_o === 1'b1) begin
      if (wait_first) check("first_frame_lat", cyc - rel_cyc, 2);
      else if (have_frame) check("frame_period", cyc - last_frame, 300);
      wait_first = 1'b0;
      if (expect_seed) begin
        check("seed_pixel", {vif.red_o, vif.green_o, vif.blue_o}, 24'hB348FB);
        expect_seed = 1'b0;
      end
      have_frame = 1'b1;
      last_frame = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Stimulus: noise, bars, solid->checker mid-frame, gradient, mid-frame reset.
  initial begin
    logic ok;
    rst_i = 1'b1; mode_i = 3'd0; solid_rgb_i = '0; expect_seed = 1'b1;
    tick(3);
    rst_i = 1'b0;
    tick(950);
    mode_i = 3'd1;
    tick(600);
    mode_i = 3'd4; solid_rgb_i = 24'h102030;
    tick(450);
    mode_i = 3'd2; solid_rgb_i = 24'hFFFFFF;
    tick(400);
    mode_i = 3'd3;
    tick(600);
    mode_i = 3'd0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick(1);
      if (vif.y_o == 16'd5 && vif.x_o == 16'd3) ok = 1'b1;
    end
    check("wait_line5", ok, 1'b1);
    expect_seed = 1'b1;
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(400);
    check("seed_after_pulse", expect_seed, 1'b0);
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised video timing and test-pattern source.
- Generalises the fixed 720p timing plus free-running noise front end into one block with configurable timing, sync polarity, colour width and a selectable pattern mode.
- Runs in the pixel (parallel) clock domain and feeds the per-channel TMDS encoders directly.
- Sync, data enable and RGB outputs are mutually aligned.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync_o
- VSYNC_POL, 1, active level of vsync_o
- COLOR_WIDTH, 8, bits per channel, 1..16
- COORD_WIDTH, 16, width of x_o/y_o
- CHECKER_LOG2, 5, checker square size is 2^CHECKER_LOG2 pixels
- GRAD_SHIFT, 2, right-shift applied to x for gradient mode
- SEED_R, 16'hACE1, red LFSR seed (nonzero)
- SEED_G, 16'h1234, green LFSR seed (nonzero)
- SEED_B, 16'hBEEF, blue LFSR seed (nonzero)

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset; synchronous to clk_i, active-high
- mode_i  in  3  pattern select: 0 noise, 1 colour bars, 2 checker, 3 gradient, 4 solid, 5-7 black
- solid_rgb_i  in  3*COLOR_WIDTH  {R,G,B} used by mode 4
- hsync_o  out  1  horizontal sync, polarity per HSYNC_POL
- vsync_o  out  1  vertical sync, polarity per VSYNC_POL
- de_o  out  1  high during active pixels
- frame_o  out  1  high for pixel (0,0) only
- line_o  out  1  high for x=0 of each active line
- x_o, y_o  out  COORD_WIDTH each  coordinate of the presented pixel
- red_o, green_o, blue_o  out  COLOR_WIDTH each  pixel data

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters h: 0..H_TOTAL-1, v: 0..V_TOTAL-1. Active region first (h<H_ACTIVE, v<V_ACTIVE).
- h wraps to 0 after H_TOTAL-1 and increments v; v wraps to 0 after V_TOTAL-1 on the same cycle that h wraps.
- hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines).
- Pipeline has 2 stages; every output reflects counter state (h,v) exactly 2 cycles later. All outputs are registered.
- Reset, while rst_i high and for the 2 cycles after it falls:
  - h=v=0; sync outputs at inactive level; de_o/frame_o/line_o=0; x_o/y_o/RGB=0
  - LFSRs reload their seeds; latched mode=5 (black)
- First cycle with rst_i low presents (0,0) to the pipeline. frame_o=1, de_o=1 and x_o=y_o=0 appear 2 cycles later.
- Mode latch: mode_i and solid_rgb_i are sampled only when (h,v)=(0,0). Changes mid-frame take effect at the next frame; no tearing.
- RGB is forced to 0 whenever de is low, in every mode.
- Mode 0 (noise):
  - Three 16-bit Fibonacci LFSRs, x^16+x^14+x^13+x^11+1, shift left, new bit0 = b15^b13^b12^b10.
  - Each advances every cycle not in reset, including blanking.
  - Channel = LFSR[15:16-COLOR_WIDTH]; for COLOR_WIDTH=16 the full register.
- Mode 1 (colour bars):
  - BAR_W = H_ACTIVE/8 (integer); bar index = min(h/BAR_W, 7), from an incrementing bar counter, no divider.
  - Order: white, yellow, cyan, green, magenta, red, blue, black. "Full" channel = all ones.
- Mode 2 (checker): white if h[CHECKER_LOG2]^v[CHECKER_LOG2], else black.
- Mode 3 (gradient): all channels = (h>>GRAD_SHIFT) truncated to COLOR_WIDTH LSBs; wraps.
- Mode 4 (solid): latched solid_rgb_i.
- Modes 5-7: black.
- Reset asserted mid-frame: the next edge restarts the frame; the outputs follow the reset values above.

Test Plan:
- Bench params H 16/2/3/4, V 8/1/2/1 (H_TOTAL=25, V_TOTAL=12), rst_i 3 cycles -> outputs at reset values; frame_o=1 exactly 2 cycles after release; frame_o period 300 cycles.
- Same params -> de_o high 16 of every 25 cycles on lines 0..7; hsync_o active for 3 cycles starting at h=18; vsync_o active for lines 9..10; polarity flips with HSYNC_POL=0.
- Mode 1, H_ACTIVE=16 (BAR_W=2) -> pixels x=0,1 white, x=2,3 yellow (R=G=FF, B=0) ... x=14,15 black; blanking RGB=0.
- Mode 0 -> red_o at (0,0) = SEED_R[15:8] advanced per the polynomial by 2 cycles; sequence matches a reference model for 3 full frames.
- mode_i changed 4 to 2 mid-frame (solid_rgb_i=0x102030) -> remainder of frame stays 0x102030; next frame starts the checker.
- rst_i pulsed for 1 cycle at v=5 -> outputs reset within 1 cycle; new frame_o 3 cycles after the pulse; LFSRs restart from the seeds.
